// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hazard_pkg;

  // Register address width: instruction[10:8] = rd, instruction[7:5] = rs.
  localparam int REG_ADDR_W = 3;

  // EX-stage operand mux select encoding.
  localparam logic [1:0] FWD_REGFILE = 2'd0;  // register file read data
  localparam logic [1:0] FWD_EXMEM   = 2'd1;  // EX/MEM alu_result
  localparam logic [1:0] FWD_MEMWB   = 2'd2;  // MEM/WB write_data
  localparam logic [1:0] FWD_RETIRED = 2'd3;  // retired-writeback holding register

  // One in-flight register write tracked beside the real pipeline.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  mem_read;
  } shadow_entry_t;

  // A used source collides with a stage that will write the same register.
  // R0 is an ordinary register, so there is no zero-register exemption.
  function automatic logic src_match(shadow_entry_t e, logic [REG_ADDR_W-1:0] s, logic used);
    return used & e.valid & e.regwrite & (e.rd == s);
  endfunction

  // Youngest producer wins: EX beats MEM beats WB.
  function automatic logic [1:0] fwd_pick(logic m_ex, logic m_mem, logic m_wb);
    if (m_ex)       return FWD_EXMEM;
    else if (m_mem) return FWD_MEMWB;
    else if (m_wb)  return FWD_RETIRED;
    else            return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard request bundle and the controller's stall/forward response.
// Latency: n/a (wires only); stall/bubble combinational, selects registered.
// Backpressure: stall is the backpressure toward fetch and IF/ID.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [REG_ADDR_W-1:0] id_rs_addr;
  logic                  id_rd_used;
  logic                  id_rs_used;
  logic                  id_regwrite;
  logic                  id_mem_read;
  logic                  flush;
  logic                  stall;
  logic                  bubble;
  logic [1:0]            fwd_rd_sel;
  logic [1:0]            fwd_rs_sel;
  logic [CNT_W-1:0]      stall_count;

  // Decode side: presents the ID instruction, consumes stall/bubble/selects.
  modport master (
    output id_valid, id_rd_addr, id_rs_addr, id_rd_used, id_rs_used,
           id_regwrite, id_mem_read, flush,
    input  stall, bubble, fwd_rd_sel, fwd_rs_sel, stall_count
  );

  // Hazard controller side.
  modport slave (
    input  id_valid, id_rd_addr, id_rs_addr, id_rd_used, id_rs_used,
           id_regwrite, id_mem_read, flush,
    output stall, bubble, fwd_rd_sel, fwd_rs_sel, stall_count
  );

endinterface

// File: rtl/hazard_shadow_pipe.sv
// Three-entry shadow of the EX/MEM/WB register writes.
// Latency: one cycle per stage; an entry leaves WB three edges after entering EX.
// Backpressure: none; the chain advances every cycle, older entries are never killed.
module hazard_shadow_pipe
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  shadow_entry_t ex_d,
  output shadow_entry_t ex_q,
  output shadow_entry_t mem_q,
  output shadow_entry_t wb_q
);

  shadow_entry_t mem_d;
  shadow_entry_t wb_d;

  // Older stages simply shift; only EX takes new content from ID.
  always_comb begin
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  // Shadow stage registers, emptied on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble, EX forwarding selects, stall counter.
// Latency: stall/bubble combinational from ID; selects valid the cycle after issue.
// Backpressure: stall holds PC and IF/ID; HAZARD_FWD_EN selects forwarding vs interlock.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  shadow_entry_t    ex_d;
  shadow_entry_t    ex_q;
  shadow_entry_t    mem_q;
  shadow_entry_t    wb_q;
  logic             rd_ex, rd_mem, rd_wb;
  logic             rs_ex, rs_mem, rs_wb;
  logic             hazard;
  logic             stall_c;
  logic             bubble_c;
  logic             issue;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;

  hazard_shadow_pipe u_shadow (
    .clk   (clk),
    .rst   (rst),
    .ex_d  (ex_d),
    .ex_q  (ex_q),
    .mem_q (mem_q),
    .wb_q  (wb_q)
  );

  // Compare each used ID source against every in-flight write.
  always_comb begin
    rd_ex  = src_match(ex_q,  hz.id_rd_addr, hz.id_rd_used);
    rd_mem = src_match(mem_q, hz.id_rd_addr, hz.id_rd_used);
    rd_wb  = src_match(wb_q,  hz.id_rd_addr, hz.id_rd_used);
    rs_ex  = src_match(ex_q,  hz.id_rs_addr, hz.id_rs_used);
    rs_mem = src_match(mem_q, hz.id_rs_addr, hz.id_rs_used);
    rs_wb  = src_match(wb_q,  hz.id_rs_addr, hz.id_rs_used);
  end

  // Stall decision; flush overrides stall but still bubbles ID/EX.
  always_comb begin
`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be bypassed: its data exists after MEM.
    hazard   = (rd_ex | rs_ex) & ex_q.mem_read;
`else
    // No bypass and no regfile write-through: wait until the writer leaves WB.
    hazard   = rd_ex | rd_mem | rd_wb | rs_ex | rs_mem | rs_wb;
`endif
    stall_c  = hz.id_valid & ~hz.flush & hazard;
    bubble_c = stall_c | hz.flush;
    issue    = hz.id_valid & ~stall_c & ~hz.flush;
  end

  // Next EX shadow entry: the issuing instruction, otherwise an empty slot.
  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = hz.id_rd_addr;
      ex_d.regwrite = hz.id_regwrite;
      ex_d.mem_read = hz.id_mem_read;
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_rd_sel_d, fwd_rd_sel_q;
  logic [1:0] fwd_rs_sel_d, fwd_rs_sel_q;

  // Selects travel with the instruction into EX; empty slots read the regfile.
  always_comb begin
    fwd_rd_sel_d = FWD_REGFILE;
    fwd_rs_sel_d = FWD_REGFILE;
    if (issue) begin
      fwd_rd_sel_d = fwd_pick(rd_ex, rd_mem, rd_wb);
      fwd_rs_sel_d = fwd_pick(rs_ex, rs_mem, rs_wb);
    end
  end

  // Forwarding select registers, loaded at the ID/EX edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_rd_sel_q <= FWD_REGFILE;
      fwd_rs_sel_q <= FWD_REGFILE;
    end else begin
      fwd_rd_sel_q <= fwd_rd_sel_d;
      fwd_rs_sel_q <= fwd_rs_sel_d;
    end
  end

  assign hz.fwd_rd_sel = fwd_rd_sel_q;
  assign hz.fwd_rs_sel = fwd_rs_sel_q;
`else
  // Interlock-only build: EX always reads the register file.
  assign hz.fwd_rd_sel = FWD_REGFILE;
  assign hz.fwd_rs_sel = FWD_REGFILE;
`endif

  assign hz.stall       = stall_c;
  assign hz.bubble      = bubble_c;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queued scoreboard and a negedge monitor.
// Latency: expectations are sampled mid-cycle, after the inputs driven at posedge+1.
// Backpressure: the bench re-presents a stalled ID instruction itself.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.CNT_W(16)) ha ();
  hazard_ctrl_if #(.CNT_W(4))  hb ();

  hazard_ctrl #(.CNT_W(16)) u_dut_a (.clk(clk), .rst(rst), .hz(ha));
  hazard_ctrl #(.CNT_W(4))  u_dut_b (.clk(clk), .rst(rst), .hz(hb));

  typedef struct {
    string      tag;
    logic       stall;
    logic       bubble;
    logic [1:0] frd;
    logic [1:0] frs;
    int         cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total;
  int   passed;
  int   bcnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string tag, string field, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s.%s actual=%0d expected=%0d", tag, field, act, exp);
  endfunction

  function automatic void chk_all(exp_t e, logic st, logic bu, logic [1:0] fr, logic [1:0] fs, int cnt);
    chk(e.tag, "stall",       int'(st), int'(e.stall));
    chk(e.tag, "bubble",      int'(bu), int'(e.bubble));
    chk(e.tag, "fwd_rd_sel",  int'(fr), int'(e.frd));
    chk(e.tag, "fwd_rs_sel",  int'(fs), int'(e.frs));
    chk(e.tag, "stall_count", cnt,      e.cnt);
  endfunction

  // Drive one ID cycle on DUT w (0 = A, 1 = B) and queue what it must show.
  task automatic step(input bit w, input logic v, input logic [2:0] rd, input logic [2:0] rs,
                      input logic rdu, input logic rsu, input logic rw, input logic mr,
                      input logic fl, input logic r, input string tag,
                      input logic est, input logic ebu, input logic [1:0] efr,
                      input logic [1:0] efs, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    if (!w) begin
      ha.id_valid = v;  ha.id_rd_addr = rd; ha.id_rs_addr = rs;
      ha.id_rd_used = rdu; ha.id_rs_used = rsu;
      ha.id_regwrite = rw; ha.id_mem_read = mr; ha.flush = fl;
    end else begin
      hb.id_valid = v;  hb.id_rd_addr = rd; hb.id_rs_addr = rs;
      hb.id_rd_used = rdu; hb.id_rs_used = rsu;
      hb.id_regwrite = rw; hb.id_mem_read = mr; hb.flush = fl;
    end
    e = '{tag, est, ebu, efr, efs, ecnt};
    if (!w) qa.push_back(e);
    else    qb.push_back(e);
  endtask

  task automatic idle(input string tag, input logic [1:0] efr, input logic [1:0] efs, input int ecnt);
    step(0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, tag, 0, 0, efr, efs, ecnt);
  endtask

  // Monitor: one queued expectation per DUT per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk_all(e, ha.stall, ha.bubble, ha.fwd_rd_sel, ha.fwd_rs_sel, int'(ha.stall_count));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk_all(e, hb.stall, hb.bubble, hb.fwd_rd_sel, hb.fwd_rs_sel, int'(hb.stall_count));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    ha.id_valid = 0; ha.id_rd_addr = 0; ha.id_rs_addr = 0; ha.id_rd_used = 0;
    ha.id_rs_used = 0; ha.id_regwrite = 0; ha.id_mem_read = 0; ha.flush = 0;
    hb.id_valid = 0; hb.id_rd_addr = 0; hb.id_rs_addr = 0; hb.id_rd_used = 0;
    hb.id_rs_used = 0; hb.id_regwrite = 0; hb.id_mem_read = 0; hb.flush = 0;
    repeat (2) @(posedge clk);

    //   w v rd rs du su rw mr fl r  tag            st bu frd frs cnt
    step(0,0,0, 0, 0, 0, 0, 0, 0,1, "reset",        0, 0, 0,  0,  0);
`ifdef HAZARD_FWD_EN
    step(0,1,3, 7, 1, 1, 1, 0, 0,0, "alu_add",      0, 0, 0,  0,  0);
    step(0,1,1, 3, 1, 1, 1, 0, 0,0, "alu_sub",      0, 0, 0,  0,  0);
    idle("fwd_ex", 0, 1, 0);
    step(0,1,2, 0, 0, 0, 1, 0, 0,0, "gap1_add",     0, 0, 0,  0,  0);
    idle("gap1_nop", 0, 0, 0);
    step(0,1,5, 2, 0, 1, 0, 0, 0,0, "gap1_use",     0, 0, 0,  0,  0);
    step(0,1,6, 0, 0, 0, 1, 0, 0,0, "gap2_add",     0, 0, 0,  2,  0);
    idle("gap2_nop1", 0, 0, 0);
    idle("gap2_nop2", 0, 0, 0);
    step(0,1,6, 6, 1, 1, 0, 0, 0,0, "gap2_use",     0, 0, 0,  0,  0);
    idle("fwd_wb", 3, 3, 0);
    step(0,1,4, 0, 0, 1, 1, 1, 0,0, "lw_r4",        0, 0, 0,  0,  0);
    step(0,1,4, 5, 1, 1, 1, 0, 0,0, "lu_stall",     1, 1, 0,  0,  0);
    step(0,1,4, 5, 1, 1, 1, 0, 0,0, "lu_issue",     0, 0, 0,  0,  1);
    idle("lu_fwd", 2, 0, 1);
    step(0,1,1, 0, 0, 0, 1, 1, 0,0, "lw_r1",        0, 0, 0,  0,  1);
    step(0,1,3, 1, 0, 1, 1, 0, 1,0, "flush_stall",  0, 1, 0,  0,  1);
    step(0,1,3, 1, 0, 1, 1, 0, 0,0, "post_flush",   0, 0, 0,  0,  1);
    idle("load_in_mem", 0, 2, 1);
    step(0,1,7, 0, 0, 0, 1, 1, 0,0, "lw_r7",        0, 0, 0,  0,  1);
    step(0,1,7, 7, 0, 0, 1, 0, 0,0, "unused_src",   0, 0, 0,  0,  1);
    idle("unused_sel", 0, 0, 1);
    step(0,1,2, 7, 0, 1, 1, 1, 0,0, "lw_r2",        0, 0, 0,  0,  1);
    step(0,1,3, 2, 0, 1, 0, 0, 0,1, "rst_mid",      0, 0, 0,  0,  0);
    step(0,0,0, 0, 0, 0, 0, 0, 0,0, "post_rst",     0, 0, 0,  0,  0);
`else
    step(0,1,6, 7, 1, 1, 1, 0, 0,0, "il_add",       0, 0, 0,  0,  0);
    step(0,1,1, 6, 0, 1, 1, 0, 0,0, "il_ex",        1, 1, 0,  0,  0);
    step(0,1,1, 6, 0, 1, 1, 0, 0,0, "il_mem",       1, 1, 0,  0,  1);
    step(0,1,1, 6, 0, 1, 1, 0, 0,0, "il_wb",        1, 1, 0,  0,  2);
    step(0,1,1, 6, 0, 1, 1, 0, 0,0, "il_issue",     0, 0, 0,  0,  3);
    idle("il_sel", 0, 0, 3);
    step(0,1,1, 1, 0, 0, 1, 1, 0,0, "unused_src",   0, 0, 0,  0,  3);
    step(0,1,3, 1, 0, 1, 1, 0, 1,0, "flush_stall",  0, 1, 0,  0,  3);
    step(0,1,3, 1, 0, 1, 1, 0, 0,0, "post_flush",   1, 1, 0,  0,  3);
    step(0,1,3, 1, 0, 1, 1, 0, 0,0, "il_wb2",       1, 1, 0,  0,  4);
    step(0,1,3, 1, 0, 1, 1, 0, 0,0, "il_issue2",    0, 0, 0,  0,  5);
    step(0,1,2, 0, 0, 0, 1, 0, 0,0, "add_r2",       0, 0, 0,  0,  5);
    step(0,1,3, 2, 0, 1, 0, 0, 0,1, "rst_mid",      0, 0, 0,  0,  0);
    step(0,0,0, 0, 0, 0, 0, 0, 0,0, "post_rst",     0, 0, 0,  0,  0);
`endif

    // Saturation on the 4-bit counter: the same self-dependent instruction is
    // re-presented every cycle, so it alternates between stalling and issuing.
    bcnt = 0;
    for (int k = 0; k < 48; k++) begin
      logic       s;
      logic [1:0] fs;
`ifdef HAZARD_FWD_EN
      s  = (k % 2) == 1;
      fs = (k >= 3 && s) ? 2'd2 : 2'd0;
`else
      s  = (k % 4) != 0;
      fs = 2'd0;
`endif
      step(1, 1, 3'd1, 3'd1, 0, 1, 1, 1, 0, 0, $sformatf("sat%0d", k), s, s, 2'd0, fs, bcnt);
      if (s && bcnt < 15) bcnt++;
    end

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (qa.size() == 0 && qb.size() == 0) passed++;
    else $display("FAIL drain: actual pending=%0d required=0", qa.size() + qb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
